// File: rtl/instr_exec_unit_pkg.sv
// Shared definitions for the instruction execution unit:
// opcode values, instruction field positions and MUL/DIV FSM states.
package instr_exec_unit_pkg;

    localparam int ADDR_W    = 4;
    localparam int OP_W      = 3;

    localparam int AADDR_LSB = 12;
    localparam int BADDR_LSB = 8;
    localparam int OP_LSB    = 5;
    localparam int WADDR_LSB = 1;
    localparam int WE_BIT    = 0;

    localparam logic [OP_W-1:0] OP_IMM = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_MUL = 3'b010;
    localparam logic [OP_W-1:0] OP_DIV = 3'b011;
    localparam logic [OP_W-1:0] OP_SUB = 3'b100;
    localparam logic [OP_W-1:0] OP_AND = 3'b101;
    localparam logic [OP_W-1:0] OP_OR  = 3'b110;
    localparam logic [OP_W-1:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_LOAD,
        MD_ITER,
        MD_FIN
    } md_state_t;

    // MUL and DIV share the 01x opcode space
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return op[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/instr_exec_unit_seq_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// Ports: clk, rst_n (sync, active-low), start, abort, a, b in;
//        busy, done, product, quot, rem out (results valid while done=1).
module instr_exec_unit_seq_muldiv
    import instr_exec_unit_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product,
    output logic [W-1:0]   quot,
    output logic [W-1:0]   rem
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    md_state_t      state;
    md_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic           last;

    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc_nxt;

    logic [W-1:0]   rem_q;
    logic [W-1:0]   quot_q;
    logic [W-1:0]   div_b;
    logic [W:0]     trial;
    logic [W-1:0]   trial_sub;
    logic           ge;
    logic [W-1:0]   rem_nxt;
    logic [W-1:0]   quot_nxt;

    assign last = (cnt == CNT_W'(W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MD_IDLE: begin
                if (start) state_nxt = MD_LOAD;
            end
            MD_LOAD: begin
                if (abort) state_nxt = start ? MD_LOAD : MD_IDLE;
                else       state_nxt = MD_ITER;
            end
            MD_ITER: begin
                if (abort)     state_nxt = start ? MD_LOAD : MD_IDLE;
                else if (last) state_nxt = MD_FIN;
            end
            MD_FIN: begin
                state_nxt = start ? MD_LOAD : MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == MD_LOAD) || (state == MD_ITER);
        // last step's result is taken combinationally so the owner
        // can register it on the same edge that enters FIN
        done = (state == MD_ITER) && last && !abort;
    end

    // shift-add step
    assign acc_nxt = mplier[0] ? acc + mcand : acc;

    // restoring-divide step; trial - divisor always fits W bits when taken
    assign trial     = {rem_q, quot_q[W-1]};
    assign ge        = trial >= {1'b0, div_b};
    assign trial_sub = trial[W-1:0] - div_b;
    assign rem_nxt   = ge ? trial_sub : trial[W-1:0];
    assign quot_nxt  = {quot_q[W-2:0], ge};

    assign product = acc_nxt;
    assign quot    = quot_nxt;
    assign rem     = rem_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            div_b  <= '0;
        end else if (state == MD_LOAD) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            rem_q  <= '0;
            quot_q <= a;
            div_b  <= b;
        end else if (state == MD_ITER) begin
            cnt    <= cnt + 1'b1;
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem_q  <= rem_nxt;
            quot_q <= quot_nxt;
        end
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Executes one 16-bit instruction word against a 16-entry data RAM.
// Ports: CLK_In, RST_n (sync, active-low), Instruction in;
//        Result, Disp_A, Busy, Done, Div_Zero out.
module instr_exec_unit
    import instr_exec_unit_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                CLK_In,
    input  logic                RST_n,
    input  logic [15:0]         Instruction,
    output logic [2*DATA_W-1:0] Result,
    output logic [DATA_W-1:0]   Disp_A,
    output logic                Busy,
    output logic                Done,
    output logic                Div_Zero
);

    logic [DATA_W-1:0]   ram [DEPTH];
    logic [15:0]         instr_q;

    logic [ADDR_W-1:0]   aaddr;
    logic [ADDR_W-1:0]   baddr;
    logic [ADDR_W-1:0]   waddr;
    logic [OP_W-1:0]     opcode;
    logic                we;

    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] alu_res;

    logic                is_new;
    logic                is_md;
    logic                exec_sc;
    logic                upd;

    logic                md_busy;
    logic                md_done;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;

    assign aaddr  = Instruction[AADDR_LSB +: ADDR_W];
    assign baddr  = Instruction[BADDR_LSB +: ADDR_W];
    assign opcode = Instruction[OP_LSB +: OP_W];
    assign waddr  = Instruction[WADDR_LSB +: ADDR_W];
    assign we     = Instruction[WE_BIT];

    assign a      = ram[aaddr];
    assign b      = ram[baddr];
    assign Disp_A = a;

    assign is_new = (Instruction != instr_q);
    assign is_md  = is_muldiv(opcode);

    // a new single-cycle op also ends any MUL/DIV in flight, so it
    // executes on its own change edge even if Busy is still high
    assign exec_sc = !is_md && (!md_busy || is_new);
    assign upd     = md_done || exec_sc;
    assign Busy    = md_busy;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = '0;
        unique case (opcode)
            OP_IMM: alu_res[ADDR_W-1:0] = baddr;
            OP_ADD: alu_res[DATA_W:0]   = sum;
            OP_SUB: alu_res[DATA_W:0]   = diff;
            OP_AND: alu_res[DATA_W-1:0] = a & b;
            OP_OR:  alu_res[DATA_W-1:0] = a | b;
            OP_XOR: alu_res[DATA_W-1:0] = a ^ b;
            OP_MUL: alu_res             = product;
            OP_DIV: alu_res             = {rem, quot};
        endcase
    end

    instr_exec_unit_seq_muldiv #(
        .W (DATA_W)
    ) u_muldiv (
        .clk     (CLK_In),
        .rst_n   (RST_n),
        .start   (is_new && is_md),
        .abort   (is_new),
        .a       (a),
        .b       (b),
        .busy    (md_busy),
        .done    (md_done),
        .product (product),
        .quot    (quot),
        .rem     (rem)
    );

    always_ff @(posedge CLK_In) begin
        if (!RST_n) begin
            instr_q  <= '0;
            Result   <= '0;
            Done     <= 1'b0;
            Div_Zero <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= '0;
            end
        end else begin
            instr_q <= Instruction;
            Done    <= md_done || (is_new && !is_md);
            if (upd) begin
                Result <= alu_res;
            end
            if (md_done && opcode == OP_DIV) begin
                Div_Zero <= (b == '0);
            end
            if (we && upd) begin
                ram[waddr] <= alu_res[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed self-checking bench for instr_exec_unit.
module tb_instr_exec_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic [7:0]  result;
    logic [3:0]  disp_a;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks;
    int failures;

    instr_exec_unit dut (
        .CLK_In      (clk),
        .RST_n       (rst_n),
        .Instruction (instr),
        .Result      (result),
        .Disp_A      (disp_a),
        .Busy        (busy),
        .Done        (done),
        .Div_Zero    (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] aa,
                                       input logic [3:0] bb,
                                       input logic [2:0] op,
                                       input logic [3:0] wa,
                                       input logic       w);
        return {aa, bb, op, wa, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [3:0] val);
        instr = mk(4'd0, val, 3'b000, addr, 1'b1);
        tick();
    endtask

    // edges until Done rises, 0 if it never does within the budget
    task automatic wait_done(output int n);
        n = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (done && n == 0) n = e;
        end
    endtask

    logic [2:0] ops  [5];
    logic [7:0] exps [5];
    int n;
    int busy_n;
    int done_at;
    int done_n;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        instr    = '0;
        tick();
        tick();
        check("rst_result", result, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz", div_zero, 1'b0);
        rst_n = 1'b1;

        // IMM write then readback
        instr = mk(4'd0, 4'd5, 3'b000, 4'd3, 1'b1);
        tick();
        check("imm_res", result, 8'h05);
        check("imm_done", done, 1'b1);
        instr = mk(4'd3, 4'd0, 3'b000, 4'd0, 1'b0);
        tick();
        check("imm_disp", disp_a, 4'd5);
        check("imm_res0", result, 8'h00);
        tick();
        check("done_pulse", done, 1'b0);

        // same-edge read sees old data
        instr = mk(4'd3, 4'd10, 3'b000, 4'd3, 1'b1);
        #1;
        check("rd_old", disp_a, 4'd5);
        tick();
        check("rd_new", disp_a, 4'd10);

        // ADD with carry and wrap
        wr(4'd1, 4'd9);
        wr(4'd2, 4'd8);
        instr = mk(4'd1, 4'd2, 3'b001, 4'd4, 1'b1);
        tick();
        check("add_res", result, 8'h11);
        instr = mk(4'd4, 4'd0, 3'b000, 4'd0, 1'b0);
        #1;
        check("add_wr", disp_a, 4'd1);
        tick();

        // remaining single-cycle ops: 3 op 5
        wr(4'd1, 4'd3);
        wr(4'd2, 4'd5);
        ops[0] = 3'b100; exps[0] = 8'h1E;
        ops[1] = 3'b101; exps[1] = 8'h01;
        ops[2] = 3'b110; exps[2] = 8'h07;
        ops[3] = 3'b111; exps[3] = 8'h06;
        ops[4] = 3'b001; exps[4] = 8'h08;
        for (int i = 0; i < 5; i++) begin
            instr = mk(4'd1, 4'd2, ops[i], 4'd0, 1'b0);
            tick();
            check($sformatf("alu_op%0d", ops[i]), result, exps[i]);
        end

        // MUL 7*6
        wr(4'd1, 4'd7);
        wr(4'd2, 4'd6);
        instr   = mk(4'd1, 4'd2, 3'b010, 4'd0, 1'b0);
        busy_n  = 0;
        done_at = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (busy) busy_n++;
            if (done && done_at == 0) done_at = e;
        end
        check("mul_busy", 16'(busy_n), 16'd5);
        check("mul_lat", 16'(done_at), 16'd6);
        check("mul_res", result, 8'h2A);

        // DIV 13/4, then by zero, then nonzero clears the flag
        wr(4'd1, 4'd13);
        wr(4'd2, 4'd4);
        instr = mk(4'd1, 4'd2, 3'b011, 4'd0, 1'b0);
        wait_done(n);
        check("div_lat", 16'(n), 16'd6);
        check("div_res", result, 8'h13);
        check("div_dz0", div_zero, 1'b0);
        wr(4'd2, 4'd0);
        instr = mk(4'd1, 4'd2, 3'b011, 4'd0, 1'b0);
        wait_done(n);
        check("dz_lat", 16'(n), 16'd6);
        check("dz_res", result, 8'hDF);
        check("dz_flag", div_zero, 1'b1);
        wr(4'd2, 4'd3);
        check("dz_sticky", div_zero, 1'b1);
        instr = mk(4'd1, 4'd2, 3'b011, 4'd0, 1'b0);
        wait_done(n);
        check("div3_res", result, 8'h14);
        check("dz_clear", div_zero, 1'b0);

        // abort MUL by ADD at cycle 2
        wr(4'd1, 4'd7);
        wr(4'd2, 4'd6);
        instr = mk(4'd1, 4'd2, 3'b010, 4'd0, 1'b0);
        tick();
        tick();
        check("ab_busy", busy, 1'b1);
        instr = mk(4'd1, 4'd2, 3'b001, 4'd0, 1'b0);
        tick();
        check("ab_done", done, 1'b1);
        check("ab_res", result, 8'h0D);
        check("ab_idle", busy, 1'b0);
        done_n = 0;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (done) done_n++;
        end
        check("ab_nodone", 16'(done_n), 16'd0);
        check("ab_hold", result, 8'h0D);

        // reset in the middle of a MUL
        instr = mk(4'd1, 4'd2, 3'b010, 4'd0, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mr_busy", busy, 1'b0);
        check("mr_res", result, 8'h00);
        check("mr_ram1", disp_a, 4'd0);
        instr = mk(4'd4, 4'd0, 3'b000, 4'd0, 1'b0);
        #1;
        check("mr_ram4", disp_a, 4'd0);
        rst_n = 1'b1;
        tick();
        check("rel_res", result, 8'h00);
        check("rel_busy", busy, 1'b0);
        instr = mk(4'd2, 4'd0, 3'b000, 4'd0, 1'b0);
        tick();
        check("rel_ram2", disp_a, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
